// File: rtl/divider_core.sv
// Iterative unsigned restoring divider: one shift/subtract step per clock.
// Drives the upstream Divisor register write strobe for one cycle (LOAD).
// It then iterates WIDTH times on that register's output.
// Results and a divide-by-zero flag are returned with a one-cycle ready pulse.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   start          division request, honoured only in IDLE
//   dividend_in    dividend, captured when start is accepted
//   divisor_val    Divisor register output, stable from RUN onwards
//   divisor_w_ctrl write strobe to the Divisor register (high in LOAD)
//   busy           high in LOAD and RUN
//   ready          one-cycle pulse in DONE
//   div_by_zero    set when the divisor was zero; held until next accept
//   quotient_out   registered quotient
//   remainder_out  registered remainder
module divider_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_val,
    output logic             divisor_w_ctrl,
    output logic             busy,
    output logic             ready,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out
);

    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned TW = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [RW-1:0]   rem_reg;
    logic [RW-1:0]   rem_step;
    logic [CW-1:0]   count;
    logic [TW-1:0]   trial;
    logic            trial_unused_bit;
    logic            accept;
    logic            zero_div;
    logic            last_step;

    // One restoring step: trial subtract on the top W+1 bits, then shift in a quotient bit.
    always_comb begin
        trial    = {1'b0, rem_reg[RW-1:WIDTH-1]} - {2'b00, divisor_val};
        rem_step = {rem_reg[RW-2:0], 1'b0};
        if (!trial[TW-1]) begin
            rem_step = {trial[WIDTH-1:0], rem_reg[WIDTH-2:0], 1'b1};
        end
    end

    // Bit WIDTH of a non-negative trial is always zero because the upper half stays below the divisor.
    assign trial_unused_bit = trial[WIDTH];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        zero_div   = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = RUN;
            end
            RUN: begin
                if ((count == '0) && (divisor_val == '0)) begin
                    zero_div   = 1'b1;
                    state_next = DONE;
                end else if (count == CW'(WIDTH - 1)) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs decode directly from the registered state.
    assign divisor_w_ctrl = (state == LOAD);
    assign busy           = (state == LOAD) || (state == RUN);
    assign ready          = (state == DONE);

    // Remainder register, iteration counter and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_reg       <= '0;
            count         <= '0;
            div_by_zero   <= 1'b0;
            quotient_out  <= '0;
            remainder_out <= '0;
        end else begin
            if (accept) begin
                rem_reg     <= {WIDTH'(0), dividend_in};
                div_by_zero <= 1'b0;
            end
            if (state == LOAD) begin
                count <= '0;
            end
            if (state == RUN) begin
                if (zero_div) begin
                    div_by_zero   <= 1'b1;
                    quotient_out  <= '1;
                    remainder_out <= rem_reg[WIDTH-1:0];
                end else begin
                    rem_reg <= rem_step;
                    count   <= count + CW'(1);
                    if (last_step) begin
                        quotient_out  <= rem_step[WIDTH-1:0];
                        remainder_out <= rem_step[RW-1:WIDTH];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_divider_core.sv
// Self-checking bench for divider_core; models the upstream Divisor register
// and compares results against plain integer division.
module tb_divider_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend_in;
    logic [31:0] divisor_in;
    logic [31:0] divisor_val = '0;
    logic        divisor_w_ctrl;
    logic        busy;
    logic        ready;
    logic        div_by_zero;
    logic [31:0] quotient_out;
    logic [31:0] remainder_out;

    int n_tests = 0;
    int n_fail  = 0;

    divider_core #(.WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .dividend_in    (dividend_in),
        .divisor_val    (divisor_val),
        .divisor_w_ctrl (divisor_w_ctrl),
        .busy           (busy),
        .ready          (ready),
        .div_by_zero    (div_by_zero),
        .quotient_out   (quotient_out),
        .remainder_out  (remainder_out)
    );

    always #5 clk = ~clk;

    // Upstream Divisor register: loads only while w_ctrl is high.
    always @(posedge clk) begin
        if (divisor_w_ctrl) divisor_val <= divisor_in;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full division; poke_n > 0 pulses a bogus start at that cycle after accept.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int poke_n);
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        int          n;
        bit          got;
        bit          busy_bad;
        bit          w_bad;
        edz = (b == 32'd0);
        eq  = edz ? 32'hFFFF_FFFF : a / b;
        er  = edz ? a : a % b;
        @(negedge clk);
        start       = 1'b1;
        dividend_in = a;
        divisor_in  = b;
        @(posedge clk); #1;
        start       = 1'b0;
        dividend_in = $urandom;
        check("load_w_ctrl", 64'(divisor_w_ctrl), 64'd1);
        check("load_busy", 64'(busy), 64'd1);
        n = 0; got = 0; busy_bad = 0; w_bad = 0;
        while (!got && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) divisor_in = $urandom;
            if (n == poke_n) begin
                start       = 1'b1;
                dividend_in = $urandom;
                divisor_in  = $urandom;
            end else begin
                start = 1'b0;
            end
            if (divisor_w_ctrl) w_bad = 1;
            if (ready) got = 1;
            else if (!busy) busy_bad = 1;
        end
        start = 1'b0;
        check("latency", 64'(n), edz ? 64'd2 : 64'd33);
        check("w_ctrl_once", 64'(w_bad), 64'd0);
        check("busy_in_run", 64'(busy_bad), 64'd0);
        check("done_busy", 64'(busy), 64'd0);
        check("quotient", 64'(quotient_out), 64'(eq));
        check("remainder", 64'(remainder_out), 64'(er));
        check("div_by_zero", 64'(div_by_zero), 64'(edz));
        @(posedge clk); #1;
        check("ready_pulse", 64'(ready), 64'd0);
    endtask

    // Division aborted by reset at cycle rst_n after accept.
    task automatic run_abort(input logic [31:0] a, input logic [31:0] b, input int rst_at);
        bit seen_ready;
        @(negedge clk);
        start       = 1'b1;
        dividend_in = a;
        divisor_in  = b;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < rst_at; i++) begin
            @(posedge clk); #1;
        end
        check("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_outs", {28'd0, divisor_w_ctrl, busy, ready, div_by_zero, quotient_out}, 64'd0);
        check("abort_rem", 64'(remainder_out), 64'd0);
        seen_ready = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready || busy) seen_ready = 1;
        end
        check("abort_idle", 64'(seen_ready), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        reset       = 1'b1;
        start       = 1'b0;
        dividend_in = '0;
        divisor_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {28'd0, divisor_w_ctrl, busy, ready, div_by_zero, quotient_out}, 64'd0);
        check("reset_rem", 64'(remainder_out), 64'd0);
        reset = 1'b0;

        run_div(32'd100, 32'd7, 0);
        run_div(32'hFFFF_FFFF, 32'd1, 0);
        run_div(32'hFF00_F0F0, 32'h10, 0);
        run_div(32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);
        run_div(32'd5, 32'd0, 0);
        run_div(32'd1234567, 32'd89, 10);
        run_abort(32'd987654, 32'd321, 15);
        run_div(32'd100, 32'd7, 0);

        for (int k = 0; k < 20; k++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 255));
                2:       rb = $urandom;
                default: rb = ra >> $urandom_range(0, 31);
            endcase
            run_div(ra, rb, (k % 4 == 0) ? 5 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
